// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver (optional even parity) with valid/ack byte handoff.
// Latency: data_valid rises 3+HALF_PERIOD+9*BIT_PERIOD clk after the rx falling edge (+BIT_PERIOD with parity).
// Backpressure: none on the line; a byte completing while data_valid=1 and no data_ack is dropped and overrun is set.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   rx            asynchronous serial input, idle high
//   data_out      last accepted byte (held until the next accepted byte)
//   data_valid    data_out not yet acknowledged; data_ack clears it
//   frame_err     one-cycle pulse when the stop bit is sampled low
//   overrun       sticky until acknowledged: a byte was dropped
//   parity_err    one-cycle pulse on even-parity mismatch (tied 0 when parity is off)
//   busy          receiver is not idle
// Optional feature macro: UART_RX_PARITY_EN (start, 8 data, even parity, stop).
module uart_rx #(
   parameter int BAUD_RATE   = 9600,
   parameter int CLK_FREQ    = 50000000,
   parameter int BIT_PERIOD  = CLK_FREQ / BAUD_RATE,
   parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ack,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err,
   output logic       busy
);

   localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

`ifdef UART_RX_PARITY_EN
   localparam state_t AFTER_DATA = S_PARITY;
`else
   localparam state_t AFTER_DATA = S_STOP;
`endif

   state_t      state, next_state;
   logic        rx_meta, rx_s;
   logic [15:0] clk_counter;
   logic [2:0]  bit_count;
   logic [7:0]  shift_reg;
   logic        half_hit, bit_hit;
   logic        cnt_clr, sample_data, stop_good, stop_bad;
`ifdef UART_RX_PARITY_EN
   logic        sample_par, par_bit;
`endif

   // Both flops preset to 1 so a reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign half_hit = (clk_counter == HALF_LAST);
   assign bit_hit  = (clk_counter == BIT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (!rx_s) next_state = S_START;
         // Mid-start sample high means the falling edge was a glitch.
         S_START:  if (half_hit) next_state = rx_s ? S_IDLE : S_DATA;
         S_DATA:   if (bit_hit && bit_count == 3'd7) next_state = AFTER_DATA;
         S_PARITY: if (bit_hit) next_state = S_STOP;
         S_STOP:   if (bit_hit) next_state = rx_s ? S_IDLE : S_BREAK;
         // A low stop bit may be a line break; never reframe until the line idles.
         S_BREAK:  if (rx_s) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != S_IDLE);
      cnt_clr     = 1'b0;
      sample_data = 1'b0;
      stop_good   = 1'b0;
      stop_bad    = 1'b0;
`ifdef UART_RX_PARITY_EN
      sample_par  = 1'b0;
`endif
      case (state)
         S_START: cnt_clr = half_hit;
         S_DATA: begin
            cnt_clr     = bit_hit;
            sample_data = bit_hit;
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            cnt_clr    = bit_hit;
            sample_par = bit_hit;
         end
`endif
         S_STOP: begin
            cnt_clr   = bit_hit;
            stop_good = bit_hit && rx_s;
            stop_bad  = bit_hit && !rx_s;
         end
         default: cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_counter <= '0;
         bit_count   <= '0;
         shift_reg   <= '0;
      end else begin
         clk_counter <= cnt_clr ? '0 : clk_counter + 16'd1;
         if (state == S_START)  bit_count <= '0;
         else if (sample_data)  bit_count <= bit_count + 3'd1;
         // LSB arrives first, so shift right and insert at the top.
         if (sample_data) shift_reg <= {rx_s, shift_reg[7:1]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         if (stop_good) begin
            // An ack in the same cycle frees the slot for the new byte.
            if (!data_valid || data_ack) begin
               data_out   <= shift_reg;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (data_ack && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (sample_par) par_bit <= rx_s;
         // Even parity: received bit must equal the XOR of the data bits.
         parity_err <= (stop_good || stop_bad) && (par_bit != ^shift_reg);
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int BIT  = 16;
   localparam int HALF = BIT / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NB  = 10;
   localparam bit PAR = 1'b1;
`else
   localparam int NB  = 9;
   localparam bit PAR = 1'b0;
`endif
   // Edge of the stop sample relative to the edge after which rx fell:
   // 2 sync flops + IDLE detect, half a bit to mid-start, NB bit periods more.
   localparam int STOP_OFS = 3 + HALF + NB * BIT;
   localparam int FRAME    = (NB + 1) * BIT;
   localparam int NEVER    = 32'h7fffffff;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       rx       = 1'b1;
   logic       data_ack = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, frame_err, overrun, parity_err, busy;

   uart_rx #(.BIT_PERIOD(BIT)) dut (
      .clk(clk), .reset_n(reset_n), .rx(rx),
      .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
      .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         at;
      logic [7:0] b;
      bit         ok;
      bit         perr;
   } ev_t;

   ev_t  sched[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   b_start = 0, b_end = 0;
   int   ack_at = -1;
   bit   ack_rand = 1'b0;
   int   ferr_seen = 0, perr_seen = 0;
   logic [7:0] m_data = '0;
   logic m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0, m_busy = 1'b0;
   bit   hit;
   ev_t  cur;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: frame outcomes are scheduled by the driver at the arithmetic
   // stop-sample edge; here only the consumer handshake is applied per edge.
   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
         sched.delete();
      end else begin
         hit = (sched.size() > 0) && (sched[0].at == cyc);
         m_ferr = 1'b0;
         m_perr = 1'b0;
         if (hit) begin
            cur    = sched.pop_front();
            m_ferr = !cur.ok;
            m_perr = cur.perr;
         end
         if (hit && cur.ok) begin
            if (!m_valid || data_ack) begin
               m_data  = cur.b;
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (data_ack && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
         end
      end
      m_busy = (cyc >= b_start) && (cyc < b_end);
   end

   always @(negedge clk) begin
      if (reset_n && cyc > 0) begin
         chk("outputs{valid,data,ovr,ferr,perr,busy}",
             32'({data_valid, data_out, overrun, frame_err, parity_err, busy}),
             32'({m_valid, m_data, m_ovr, m_ferr, m_perr, m_busy}));
         if (frame_err)  ferr_seen++;
         if (parity_err) perr_seen++;
      end
   end

   always @(posedge clk) begin
      #2;
      if (ack_rand) data_ack = ($urandom_range(0, 3) == 0);
      else          data_ack = (cyc + 1 == ack_at);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ack_now();
      ack_at = cyc + 1;
      tick(3);
   endtask

   task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int hold);
      int  e0;
      ev_t e;
      e0     = cyc;
      rx     = 1'b0;
      e.at   = e0 + STOP_OFS;
      e.b    = b;
      e.ok   = stop_ok;
      e.perr = PAR && !par_ok;
      sched.push_back(e);
      b_start = e0 + 3;
      b_end   = stop_ok ? e0 + STOP_OFS : NEVER;
      tick(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(BIT);
      end
      if (PAR) begin
         rx = par_ok ? ^b : ~^b;
         tick(BIT);
      end
      rx = stop_ok;
      tick(BIT + (stop_ok ? 0 : hold));
      rx = 1'b1;
      if (!stop_ok) b_end = cyc + 3;
   endtask

   initial begin
      logic [7:0] rb;
      bit         bad;
      int         fs, ps, s0;

      tick(4);
      chk("reset_state", 32'({data_valid, data_out, overrun, frame_err, parity_err, busy}), 0);
      reset_n = 1'b1;
      tick(3);

      // Basic byte
      send(8'hA5, 1'b1, 1'b1, 0);
      tick(4);
      chk("t1_valid", 32'(data_valid), 1);
      chk("t1_data", 32'(data_out), 'hA5);
      chk("t1_busy", 32'(busy), 0);
      ack_now();
      chk("t1_ack_clears", 32'(data_valid), 0);

      // Start-bit glitch
      rx = 1'b0;
      b_start = cyc + 3;
      b_end   = cyc + 3 + HALF;
      tick(5);
      rx = 1'b1;
      tick(20);
      chk("t2_busy", 32'(busy), 0);
      chk("t2_no_valid", 32'(data_valid), 0);

      // Framing error with long low line, then a clean byte
      fs = ferr_seen;
      send(8'h3C, 1'b0, 1'b1, 40 - BIT);
      chk("t3_busy_in_break", 32'(busy), 1);
      tick(6);
      chk("t3_ferr_pulses", 32'(ferr_seen - fs), 1);
      chk("t3_no_valid", 32'(data_valid), 0);
      chk("t3_idle", 32'(busy), 0);
      send(8'h55, 1'b1, 1'b1, 0);
      tick(4);
      chk("t3_next_data", 32'(data_out), 'h55);
      ack_now();

      // Overrun
      send(8'h11, 1'b1, 1'b1, 0);
      send(8'h22, 1'b1, 1'b1, 0);
      tick(4);
      chk("t4_data_kept", 32'(data_out), 'h11);
      chk("t4_overrun", 32'(overrun), 1);
      ack_now();
      chk("t4_ack_valid", 32'(data_valid), 0);
      chk("t4_ack_ovr", 32'(overrun), 0);

      // Back-to-back with ack coinciding with the second accept
      s0 = cyc;
      ack_at = s0 + FRAME + STOP_OFS;
      send(8'h00, 1'b1, 1'b1, 0);
      send(8'hFF, 1'b1, 1'b1, 0);
      tick(4);
      chk("t5_data", 32'(data_out), 'hFF);
      chk("t5_valid", 32'(data_valid), 1);
      chk("t5_ovr", 32'(overrun), 0);

`ifdef UART_RX_PARITY_EN
      ack_now();
      ps = perr_seen;
      send(8'h07, 1'b1, 1'b0, 0);
      tick(4);
      chk("t6_perr_pulses", 32'(perr_seen - ps), 1);
      chk("t6_data", 32'(data_out), 'h07);
`else
      ps = 0;
`endif

      // Reset in the middle of a frame
      rx = 1'b0;
      b_start = cyc + 3;
      b_end   = NEVER;
      tick(3 * BIT + 5);
      reset_n = 1'b0;
      rx      = 1'b1;
      b_start = 0;
      b_end   = 0;
      tick(1);
      chk("t6_reset_outputs", 32'({data_valid, data_out, overrun, frame_err, parity_err, busy}), 0);
      tick(2);
      reset_n = 1'b1;
      tick(20);
      send(8'h81, 1'b1, 1'b1, 0);
      tick(4);
      chk("t6_after_reset_data", 32'(data_out), 'h81);
      chk("t6_after_reset_valid", 32'(data_valid), 1);
      ack_now();

      // Randomized traffic with random consumer
      ack_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         rb  = 8'($urandom);
         bad = ($urandom_range(0, 7) == 0);
         send(rb, !bad, $urandom_range(0, 5) != 0, $urandom_range(4, 30));
         tick(bad ? $urandom_range(4, 12) : $urandom_range(0, 12));
      end
      ack_rand = 1'b0;
      tick(4);
      ack_now();
      chk("rand_drained", 32'(data_valid), 0);
      chk("rand_idle", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
